// File: rtl/lane_fifo_if.sv
// lane_fifo_if: multi-lane write/read handshake bundle for lane_fifo
interface lane_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int MAX_WR     = 4,
  parameter int MAX_RD     = 2
);
  localparam int WCW = $clog2(MAX_WR + 1);
  localparam int RCW = $clog2(MAX_RD + 1);
  localparam int LW  = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] data_in [MAX_WR];
  logic [WCW-1:0]        wr_count;
  logic                  write_enable;
  logic                  read_enable;
  logic [RCW-1:0]        rd_count;
  logic [DATA_WIDTH-1:0] data_out [MAX_RD];
  logic                  valid;
  logic                  ready;
  logic                  full;
  logic                  empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output data_in, wr_count, write_enable, read_enable, rd_count,
    input  data_out, valid, ready, full, empty, level, overflow, underflow
  );
  modport slave (
    input  data_in, wr_count, write_enable, read_enable, rd_count,
    output data_out, valid, ready, full, empty, level, overflow, underflow
  );
endinterface

// File: rtl/lane_fifo.sv
// lane_fifo: circular FIFO accepting up to MAX_WR writes and MAX_RD reads per cycle
module lane_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int MAX_WR     = 4,
  parameter int MAX_RD     = 2
) (
  input logic       clk,
  input logic       rst,
  lane_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         lvl;
  logic                  wr_ok, rd_ok;
  function automatic logic [PW-1:0] wrap(int p);
    return PW'(p >= DEPTH ? p - DEPTH : p);
  endfunction
  // acceptance uses start-of-cycle level only, so same-cycle traffic never helps
  assign wr_ok = bus.write_enable && int'(bus.wr_count) <= MAX_WR && int'(bus.wr_count) <= DEPTH - int'(lvl);
  assign rd_ok = bus.read_enable && int'(bus.rd_count) <= MAX_RD && int'(bus.rd_count) <= int'(lvl);
  assign bus.level = lvl;
  assign bus.full  = int'(lvl) == DEPTH;
  assign bus.empty = lvl == '0;
  assign bus.ready = int'(lvl) <= DEPTH - MAX_WR;
  always_ff @(posedge clk)
    if (!rst && wr_ok)
      for (int i = 0; i < MAX_WR; i++)
        if (i < int'(bus.wr_count)) mem[wrap(int'(wr_ptr) + i)] <= bus.data_in[i];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      lvl           <= '0;
      bus.data_out  <= '{default: '0};
      bus.valid     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wrap(int'(wr_ptr) + int'(bus.wr_count));
      if (rd_ok) rd_ptr <= wrap(int'(rd_ptr) + int'(bus.rd_count));
      if (rd_ok && bus.rd_count != '0)
        for (int i = 0; i < MAX_RD; i++)
          bus.data_out[i] <= i < int'(bus.rd_count) ? mem[wrap(int'(rd_ptr) + i)] : '0;
      bus.valid     <= rd_ok && bus.rd_count != '0;
      lvl           <= LW'(int'(lvl) + (wr_ok ? int'(bus.wr_count) : 0) - (rd_ok ? int'(bus.rd_count) : 0));
      bus.overflow  <= bus.overflow | (bus.write_enable && !wr_ok);
      bus.underflow <= bus.underflow | (bus.read_enable && !rd_ok);
    end
  end
endmodule

// File: tb/tb_lane_fifo.sv
// tb_lane_fifo: directed and random checks of lane_fifo against a queue model
module tb_lane_fifo;
  logic clk = 0;
  logic rst = 1;
  lane_fifo_if #(.DATA_WIDTH(8), .DEPTH(8), .MAX_WR(4), .MAX_RD(2)) bus ();
  lane_fifo #(.DATA_WIDTH(8), .DEPTH(8), .MAX_WR(4), .MAX_RD(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  logic [7:0] din [4];
  logic [7:0] q [$];
  logic [7:0] m_dout [2];
  bit m_valid, m_ov, m_un;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(bus.level), q.size());
    chk("empty", 32'(bus.empty), q.size() == 0);
    chk("full", 32'(bus.full), q.size() == 8);
    chk("ready", 32'(bus.ready), 8 - q.size() >= 4);
    chk("valid", 32'(bus.valid), m_valid);
    chk("dout0", 32'(bus.data_out[0]), m_dout[0]);
    chk("dout1", 32'(bus.data_out[1]), m_dout[1]);
    chk("overflow", 32'(bus.overflow), m_ov);
    chk("underflow", 32'(bus.underflow), m_un);
  endtask

  // one clock: drive, advance the model from the start-of-cycle state, then compare
  task automatic step(bit r, bit we, int wc, bit re, int rc);
    bit wa, ra;
    @(negedge clk);
    rst = r;
    bus.write_enable = we;
    bus.wr_count = 3'(wc);
    bus.read_enable = re;
    bus.rd_count = 2'(rc);
    for (int i = 0; i < 4; i++) bus.data_in[i] = din[i];
    if (r) begin
      q.delete();
      m_dout = '{default: 0};
      m_valid = 0; m_ov = 0; m_un = 0;
    end else begin
      wa = we && wc <= 4 && wc <= 8 - q.size();
      ra = re && rc <= 2 && rc <= q.size();
      m_valid = ra && rc > 0;
      if (m_valid)
        for (int i = 0; i < 2; i++) m_dout[i] = i < rc ? q.pop_front() : 8'h00;
      if (wa) for (int i = 0; i < wc; i++) q.push_back(din[i]);
      m_ov |= we && !wa;
      m_un |= re && !ra;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int next_wr, exp_next, wc, rc, remain;
    bit we, re;
    din = '{default: 0};
    bus.write_enable = 0; bus.read_enable = 0; bus.wr_count = 0; bus.rd_count = 0;
    for (int i = 0; i < 4; i++) bus.data_in[i] = 0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ready", 32'(bus.ready), 1);
    din = '{1, 2, 3, 4};
    step(0, 1, 4, 0, 0);
    din = '{5, 6, 7, 8'hee};
    step(0, 1, 3, 0, 0);
    chk("lvl7", 32'(bus.level), 7);
    chk("notready7", 32'(bus.ready), 0);
    din = '{8'h55, 8'h66, 0, 0};
    step(0, 1, 2, 0, 0);
    chk("ovf_reject", 32'(bus.overflow), 1);
    chk("lvl7b", 32'(bus.level), 7);
    step(0, 0, 0, 1, 2);
    chk("rd_12_l0", 32'(bus.data_out[0]), 1);
    chk("rd_12_l1", 32'(bus.data_out[1]), 2);
    step(0, 0, 0, 1, 1);
    chk("rd_3_l0", 32'(bus.data_out[0]), 3);
    chk("rd_3_l1", 32'(bus.data_out[1]), 0);
    chk("lvl4", 32'(bus.level), 4);
    din = '{8'h10, 8'h11, 8'h12, 8'h13};
    step(0, 1, 4, 1, 2);
    chk("lvl6", 32'(bus.level), 6);
    din = '{8'h20, 8'h21, 8'h22, 8'h23};
    step(0, 1, 4, 1, 2);
    chk("lvl4_rej", 32'(bus.level), 4);
    step(0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    next_wr = 1;
    exp_next = 1;
    for (int n = 0; n < 400 && exp_next <= 40; n++) begin
      remain = 41 - next_wr;
      wc = $urandom_range(1, 4);
      if (wc > remain) wc = remain;
      we = wc > 0 && wc <= 8 - q.size();
      for (int i = 0; i < 4; i++) din[i] = 8'(next_wr + i);
      rc = $urandom_range(1, 2);
      re = rc <= q.size();
      step(0, we, wc, re, rc);
      if (we) next_wr += wc;
      if (re)
        for (int i = 0; i < rc; i++) begin
          chk("stream", 32'(bus.data_out[i]), exp_next);
          exp_next++;
        end
    end
    chk("stream_done", exp_next, 41);
    chk("stream_ovf", 32'(bus.overflow), 0);
    chk("stream_unf", 32'(bus.underflow), 0);

    step(1, 0, 0, 0, 0);
    din = '{8'h77, 0, 0, 0};
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 2);
    chk("unf_set", 32'(bus.underflow), 1);
    chk("unf_valid", 32'(bus.valid), 0);
    chk("unf_lvl1", 32'(bus.level), 1);
    step(1, 1, 4, 1, 1);
    chk("rst_mid_lvl", 32'(bus.level), 0);
    chk("rst_mid_unf", 32'(bus.underflow), 0);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
